// File: rtl/serial_bit_order_rx.sv
// Serial-to-parallel receiver that restores per-word bit order (MSB- or LSB-first).
// Optional even-parity bit per word when SERIAL_RX_PARITY_EN is defined.
module serial_bit_order_rx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
`ifdef SERIAL_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun,
  input  logic             overrun_clr
);

`ifdef SERIAL_RX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
  localparam int unsigned CW    = CNT_W + 1;
`else
  localparam int unsigned NBITS = WIDTH;
  localparam int unsigned CW    = CNT_W;
`endif

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             lsb_q, lsb_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             order_c;
  logic [WIDTH-1:0] word_c;
  logic             complete_c;
`ifdef SERIAL_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
  logic             pbit_c;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      shreg_q      <= '0;
      lsb_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      lsb_q        <= lsb_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
      par_q        <= par_d;
      perr_q       <= perr_d;
`endif
    end
  end

  // Next-state: assembly, completion, output buffer and overrun
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    lsb_d        = lsb_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q & ~overrun_clr;
    order_c      = lsb_q;
    word_c       = shreg_q;
    complete_c   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d        = par_q;
    perr_d       = perr_q;
    pbit_c       = par_q;
`endif

    if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (sin_valid) begin
          // Order is latched on the first bit and held for the rest of the word
          if (cnt_q == '0) begin
            order_c = lsb_first;
            lsb_d   = lsb_first;
          end
          if (cnt_q < CW'(WIDTH)) begin
            word_c = order_c ? {sin, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], sin};
          end
`ifdef SERIAL_RX_PARITY_EN
          else begin
            pbit_c = sin;
          end
          par_d = pbit_c;
`endif
          shreg_d = word_c;
          if (cnt_q == CW'(NBITS - 1)) begin
            if (!dout_valid_q || dout_ready) begin
              complete_c = 1'b1;
              cnt_d      = '0;
            end else begin
              state_d = FULL;
              cnt_d   = CW'(NBITS);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (sin_valid) overrun_d = 1'b1;
        if (dout_ready) begin
          complete_c = 1'b1;
          cnt_d      = '0;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (complete_c) begin
      dout_d       = word_c;
      dout_valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
      perr_d       = (^word_c) ^ pbit_c;
`endif
    end
  end

  assign sin_ready  = (state_q == COLLECT);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
